register_scoreboard: RTL and testbench
======================================

Name: register_scoreboard

Overview:
Tracks in-flight register writes between decode and writeback, and issues stalls for read-after-write hazards.
- Decode presents each instruction's source and destination registers before handing it to execute.
- The execute, memory and writeback stages report retiring writes back.
- This is the issue scheduler for the single-cycle execute datapath. It stays correct when multi-cycle mul/div makes instruction latency variable.

Parameters:
NUM_REGISTERS, 32, architectural register count (localparam).
REGISTER_INDEXING_WIDTH, $clog2(NUM_REGISTERS), register index width (localparam).
MAX_IN_FLIGHT, 4, maximum outstanding writes to one register.
COUNT_WIDTH, $clog2(MAX_IN_FLIGHT + 1), per-register counter width (localparam).

Ports:
clk  input  1  clock.
rst  input  1  reset, synchronous, active-high.
issue_valid  input  1  decode presents an instruction this cycle.
issue_read_1_register  input  REGISTER_INDEXING_WIDTH  source register 1.
issue_read_1_enabled  input  1  source 1 is actually read.
issue_read_2_register  input  REGISTER_INDEXING_WIDTH  source register 2.
issue_read_2_enabled  input  1  source 2 is actually read.
issue_write_register  input  REGISTER_INDEXING_WIDTH  destination register.
issue_write_enabled  input  1  instruction writes a register.
issue_stall  output  1  instruction must not issue this cycle.
retire_valid  input  1  a write to retire_register commits this cycle.
retire_register  input  REGISTER_INDEXING_WIDTH  register being written back.
flush  input  1  discard all in-flight tracking (pipeline flush).
busy  output  1  at least one write is outstanding.
underflow_error  output  1  sticky: a retire arrived for a register whose count was 0.

Behaviour:
- Each register r = 1..NUM_REGISTERS-1 has a count[r] of COUNT_WIDTH bits. Register 0 is never tracked: its count reads 0, and issues or retires to it are ignored.
- Effective count (combinational): eff[r] = count[r] - 1 when retire_valid && retire_register == r && count[r] != 0; otherwise eff[r] = count[r]. This is the same-cycle retire bypass.
- Read hazard: (issue_read_1_enabled && eff[read_1] != 0) || (issue_read_2_enabled && eff[read_2] != 0).
- Saturation hazard: issue_write_enabled && eff[write] == MAX_IN_FLIGHT.
- issue_stall = rst || flush || (issue_valid && (read hazard || saturation hazard)).
  - Purely combinational; no registered latency.
  - When issue_valid is 0, issue_stall = rst || flush.
- Accept = issue_valid && !issue_stall.
- Count update at posedge, when not rst and not flush:
  - Increment on accept && issue_write_enabled && write != 0.
  - Decrement on retire_valid && count != 0.
  - Issue and retire to the same register in the same cycle leaves the count unchanged.
- Underflow: retire_valid, retire_register != 0 and count == 0 sets underflow_error on the next edge. The count stays 0. Only rst clears the flag.
- flush has priority over issue and retire in the same cycle. All counts become 0 at the next edge, and retires arriving that cycle are discarded without raising underflow_error. underflow_error keeps its value.
- busy = OR of all count[r] != 0, taken from registered state (no bypass).
- Reset: all counts 0, busy 0, underflow_error 0, issue_stall 1 while rst is high. rst mid-operation discards all counts at the next edge.
- Decode must hold the instruction's fields stable while issue_stall is high. Each retire corresponds to exactly one previously accepted write.

Test Plan:
- Reset release, issue_valid=1, read x5, write x6 -> issue_stall=0; count[6]=1 and busy=1 on the next cycle.
- Issue write x6, then next cycle issue read_1=x6 -> issue_stall=1. Hold it and assert retire x6 -> stall drops that same cycle, instruction accepted, count[6]=0.
- Four issues writing x7 with no retire, then a fifth -> fifth stalls (count[7]=4). Retire x7 in that cycle -> fifth accepted, count[7] stays 4.
- Issue write x8 and retire x8 in the same cycle, starting from count 1 -> count stays 1. Write x0 with read x0 -> never stalls, busy stays 0.
- Retire x9 with count[9]=0 -> underflow_error=1 next cycle and stays high. It survives a flush and clears only on rst.
- Counts x3=2 and x4=1, then flush with a simultaneous issue writing x3 -> issue_stall=1; next cycle all counts 0, busy=0.

Source files
------------

// File: rtl/register_scoreboard_if.sv
// register_scoreboard_if: decode-issue, retire and status signals of the register scoreboard.
//   master : decode / writeback side (drives issue_*, retire_*, flush; observes status)
//   slave  : scoreboard side (observes requests; drives issue_stall, busy, underflow_error)
interface register_scoreboard_if #(
    parameter int unsigned REGISTER_INDEXING_WIDTH = 5
);
    logic                               issue_valid;
    logic [REGISTER_INDEXING_WIDTH-1:0] issue_read_1_register;
    logic                               issue_read_1_enabled;
    logic [REGISTER_INDEXING_WIDTH-1:0] issue_read_2_register;
    logic                               issue_read_2_enabled;
    logic [REGISTER_INDEXING_WIDTH-1:0] issue_write_register;
    logic                               issue_write_enabled;
    logic                               issue_stall;
    logic                               retire_valid;
    logic [REGISTER_INDEXING_WIDTH-1:0] retire_register;
    logic                               flush;
    logic                               busy;
    logic                               underflow_error;

    modport master (
        output issue_valid, issue_read_1_register, issue_read_1_enabled,
               issue_read_2_register, issue_read_2_enabled,
               issue_write_register, issue_write_enabled,
               retire_valid, retire_register, flush,
        input  issue_stall, busy, underflow_error
    );

    modport slave (
        input  issue_valid, issue_read_1_register, issue_read_1_enabled,
               issue_read_2_register, issue_read_2_enabled,
               issue_write_register, issue_write_enabled,
               retire_valid, retire_register, flush,
        output issue_stall, busy, underflow_error
    );
endinterface

// File: rtl/register_scoreboard.sv
// register_scoreboard: counts outstanding writes per architectural register and stalls
// decode on read-after-write hazards or when a register's in-flight count is saturated.
//   clk, rst : clock, synchronous active-high reset
//   sb       : register_scoreboard_if.slave (issue request, retire report, flush,
//              issue_stall (combinational), busy, sticky underflow_error)
module register_scoreboard #(
    parameter int unsigned MAX_IN_FLIGHT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    register_scoreboard_if.slave  sb
);
    localparam int unsigned NUM_REGISTERS           = 32;
    localparam int unsigned REGISTER_INDEXING_WIDTH = $clog2(NUM_REGISTERS);
    localparam int unsigned COUNT_WIDTH             = $clog2(MAX_IN_FLIGHT + 1);

    logic [COUNT_WIDTH-1:0] count [NUM_REGISTERS];
    logic [COUNT_WIDTH-1:0] eff   [NUM_REGISTERS];
    logic                   underflow_q;
    logic                   read_hazard;
    logic                   saturation_hazard;
    logic                   stall;
    logic                   accept;

    // Effective counts: a retire landing this cycle already frees its register.
    always_comb begin
        for (int unsigned r = 0; r < NUM_REGISTERS; r++) begin
            eff[r] = count[r];
            if (r != 0 && sb.retire_valid &&
                sb.retire_register == REGISTER_INDEXING_WIDTH'(r) &&
                count[r] != '0) begin
                eff[r] = count[r] - COUNT_WIDTH'(1);
            end
        end
    end

    // Hazard detection and issue decision.
    always_comb begin
        read_hazard = (sb.issue_read_1_enabled && eff[sb.issue_read_1_register] != '0) ||
                      (sb.issue_read_2_enabled && eff[sb.issue_read_2_register] != '0);
        saturation_hazard = sb.issue_write_enabled &&
                            eff[sb.issue_write_register] == COUNT_WIDTH'(MAX_IN_FLIGHT);
        stall  = rst || sb.flush || (sb.issue_valid && (read_hazard || saturation_hazard));
        accept = sb.issue_valid && !stall;
    end

    // Per-register counters; register 0 is hardwired to zero.
    always_ff @(posedge clk) begin
        if (rst || sb.flush) begin
            for (int unsigned r = 0; r < NUM_REGISTERS; r++) begin
                count[r] <= '0;
            end
        end else begin
            for (int unsigned r = 0; r < NUM_REGISTERS; r++) begin
                if (r == 0) begin
                    count[r] <= '0;
                end else begin
                    logic inc;
                    logic dec;
                    inc = accept && sb.issue_write_enabled &&
                          sb.issue_write_register == REGISTER_INDEXING_WIDTH'(r);
                    dec = sb.retire_valid && count[r] != '0 &&
                          sb.retire_register == REGISTER_INDEXING_WIDTH'(r);
                    if (inc && !dec) begin
                        count[r] <= count[r] + COUNT_WIDTH'(1);
                    end else if (dec && !inc) begin
                        count[r] <= count[r] - COUNT_WIDTH'(1);
                    end
                end
            end
        end
    end

    // Sticky underflow flag; retires discarded by a flush never raise it.
    always_ff @(posedge clk) begin
        if (rst) begin
            underflow_q <= 1'b0;
        end else if (!sb.flush && sb.retire_valid && sb.retire_register != '0 &&
                     count[sb.retire_register] == '0) begin
            underflow_q <= 1'b1;
        end
    end

    // busy reflects registered counts only.
    always_comb begin
        sb.busy = 1'b0;
        for (int unsigned r = 1; r < NUM_REGISTERS; r++) begin
            if (count[r] != '0) begin
                sb.busy = 1'b1;
            end
        end
    end

    assign sb.issue_stall     = stall;
    assign sb.underflow_error = underflow_q;
endmodule

// File: tb/tb_register_scoreboard.sv
// tb_register_scoreboard: table-driven directed vectors, a hand-written stalled-hold
// sequence, and randomized traffic checked against a per-register counting model.
module tb_register_scoreboard;
    logic clk;
    logic rst;

    register_scoreboard_if sb_if ();

    register_scoreboard dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       iv;
        logic [4:0] r1;
        logic       r1e;
        logic [4:0] r2;
        logic       r2e;
        logic [4:0] w;
        logic       we;
        logic       rv;
        logic [4:0] rr;
        logic       fl;
        logic       e_stall;
        logic       e_busy;
        logic       e_uf;
    } vec_t;

    int checks = 0;
    int errors = 0;

    vec_t tbl[$];

    // Reference model: plain integer count per register plus sticky flag.
    int mcnt [32];
    bit muf;

    function automatic vec_t mk(int rs, int iv, int r1, int r1e, int r2, int r2e,
                                int w, int we, int rv, int rr, int fl,
                                int es, int eb, int eu);
        vec_t v;
        v.rst = 1'(rs);  v.iv = 1'(iv);
        v.r1 = 5'(r1);   v.r1e = 1'(r1e);
        v.r2 = 5'(r2);   v.r2e = 1'(r2e);
        v.w = 5'(w);     v.we = 1'(we);
        v.rv = 1'(rv);   v.rr = 5'(rr);
        v.fl = 1'(fl);
        v.e_stall = 1'(es); v.e_busy = 1'(eb); v.e_uf = 1'(eu);
        return v;
    endfunction

    task automatic apply(input vec_t v);
        rst                         = v.rst;
        sb_if.issue_valid           = v.iv;
        sb_if.issue_read_1_register = v.r1;
        sb_if.issue_read_1_enabled  = v.r1e;
        sb_if.issue_read_2_register = v.r2;
        sb_if.issue_read_2_enabled  = v.r2e;
        sb_if.issue_write_register  = v.w;
        sb_if.issue_write_enabled   = v.we;
        sb_if.retire_valid          = v.rv;
        sb_if.retire_register       = v.rr;
        sb_if.flush                 = v.fl;
    endtask

    task automatic check(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0b expected %0b", name, got, exp);
        end
    endtask

    // One cycle: stall sampled mid-cycle, registered status sampled after the edge.
    task automatic run_vec(input string name, input vec_t v);
        apply(v);
        #3;
        check({name, " stall"}, sb_if.issue_stall, v.e_stall);
        @(posedge clk);
        #1;
        check({name, " busy"}, sb_if.busy, v.e_busy);
        check({name, " underflow"}, sb_if.underflow_error, v.e_uf);
    endtask

    function automatic int meff(int r, bit rv, int rr);
        if (r == 0) return 0;
        if (rv && rr == r && mcnt[r] > 0) return mcnt[r] - 1;
        return mcnt[r];
    endfunction

    function automatic bit m_busy();
        for (int r = 1; r < 32; r++) if (mcnt[r] != 0) return 1'b1;
        return 1'b0;
    endfunction

    initial begin
        apply(mk(1,0,0,0,0,0,0,0,0,0,0,0,0,0));
        @(posedge clk);
        #1;

        // mk(rst,iv,r1,r1e,r2,r2e,w,we,rv,rr,flush, exp_stall,exp_busy,exp_uf)
        tbl.push_back(mk(1,1,5,1,0,0,6,1,0,0,0, 1,0,0));
        tbl.push_back(mk(0,1,5,1,0,0,6,1,0,0,0, 0,1,0));
        tbl.push_back(mk(0,1,6,1,0,0,0,0,0,0,0, 1,1,0));
        tbl.push_back(mk(0,1,6,1,0,0,0,0,1,6,0, 0,0,0));
        for (int k = 0; k < 4; k++) tbl.push_back(mk(0,1,0,0,0,0,7,1,0,0,0, 0,1,0));
        tbl.push_back(mk(0,1,0,0,0,0,7,1,0,0,0, 1,1,0));
        tbl.push_back(mk(0,1,0,0,0,0,7,1,1,7,0, 0,1,0));
        for (int k = 0; k < 3; k++) tbl.push_back(mk(0,0,0,0,0,0,0,0,1,7,0, 0,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,1,7,0, 0,0,0));
        tbl.push_back(mk(0,1,0,0,0,0,8,1,0,0,0, 0,1,0));
        tbl.push_back(mk(0,1,0,0,0,0,8,1,1,8,0, 0,1,0));
        tbl.push_back(mk(0,1,8,1,0,0,0,0,0,0,0, 1,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,1,8,0, 0,0,0));
        tbl.push_back(mk(0,1,0,1,0,1,0,1,0,0,0, 0,0,0));
        tbl.push_back(mk(0,1,0,1,0,1,0,1,0,0,0, 0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,1,9,0, 0,0,1));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,1));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,1, 1,0,1));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,1));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,0, 1,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,0));
        tbl.push_back(mk(0,1,0,0,0,0,3,1,0,0,0, 0,1,0));
        tbl.push_back(mk(0,1,0,0,0,0,3,1,0,0,0, 0,1,0));
        tbl.push_back(mk(0,1,0,0,0,0,4,1,0,0,0, 0,1,0));
        tbl.push_back(mk(0,1,0,0,0,0,3,1,0,0,1, 1,0,0));
        tbl.push_back(mk(0,1,3,1,4,1,0,0,0,0,0, 0,0,0));
        tbl.push_back(mk(0,1,0,0,0,0,4,1,0,0,0, 0,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,1,4,1, 1,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,1,12,1, 1,0,0));
        tbl.push_back(mk(0,1,0,0,0,0,10,1,0,0,0, 0,1,0));
        tbl.push_back(mk(1,1,0,0,0,0,11,1,0,0,0, 1,0,0));
        tbl.push_back(mk(0,1,10,1,11,1,0,0,0,0,0, 0,0,0));
        tbl.push_back(mk(0,1,0,0,0,0,12,1,0,0,0, 0,1,0));
        tbl.push_back(mk(0,1,12,0,12,1,0,0,0,0,0, 1,1,0));
        tbl.push_back(mk(0,1,12,0,0,0,13,1,0,0,0, 0,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,1,12,0, 0,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,1,13,0, 0,0,0));

        foreach (tbl[i]) run_vec($sformatf("vec%0d", i), tbl[i]);

        // Stalled instruction held across cycles: its write to x15 must not count.
        run_vec("hold_setup",  mk(0,1,0,0,0,0,14,1,0,0,0, 0,1,0));
        for (int k = 0; k < 3; k++)
            run_vec($sformatf("hold%0d", k), mk(0,1,14,1,0,0,15,1,0,0,0, 1,1,0));
        run_vec("hold_release", mk(0,1,14,1,0,0,15,1,1,14,0, 0,1,0));
        run_vec("hold_x15_busy", mk(0,1,0,0,15,1,0,0,0,0,0, 1,1,0));
        run_vec("hold_x15_ret",  mk(0,0,0,0,0,0,0,0,1,15,0, 0,0,0));

        // Randomized traffic against the model.
        for (int r = 0; r < 32; r++) mcnt[r] = 0;
        muf = 1'b0;
        run_vec("rand_reset", mk(1,0,0,0,0,0,0,0,0,0,0, 1,0,0));
        for (int n = 0; n < 800; n++) begin
            vec_t v;
            int   es;
            v.rst = 1'(($urandom % 97) == 0);
            v.fl  = 1'(($urandom % 31) == 0);
            v.iv  = 1'(($urandom % 4) != 0);
            v.r1  = 5'($urandom_range(0, 7));
            v.r1e = 1'($urandom % 2);
            v.r2  = 5'($urandom_range(0, 7));
            v.r2e = 1'($urandom % 2);
            v.w   = 5'($urandom_range(0, 7));
            v.we  = 1'(($urandom % 4) != 0);
            v.rv  = 1'($urandom % 2);
            v.rr  = 5'($urandom_range(0, 7));
            for (int t = 0; t < 6 && mcnt[v.rr] == 0 && ($urandom % 16) != 0; t++)
                v.rr = 5'($urandom_range(1, 7));

            es = (v.rst || v.fl) ? 1 : 0;
            if (v.iv && ((v.r1e && meff(int'(v.r1), v.rv, int'(v.rr)) != 0) ||
                         (v.r2e && meff(int'(v.r2), v.rv, int'(v.rr)) != 0) ||
                         (v.we  && meff(int'(v.w),  v.rv, int'(v.rr)) == 4)))
                es = 1;

            apply(v);
            #3;
            check($sformatf("rand%0d stall", n), sb_if.issue_stall, 1'(es));
            @(posedge clk);
            if (v.rst) begin
                for (int r = 0; r < 32; r++) mcnt[r] = 0;
                muf = 1'b0;
            end else if (v.fl) begin
                for (int r = 0; r < 32; r++) mcnt[r] = 0;
            end else begin
                if (v.rv && v.rr != 0) begin
                    if (mcnt[v.rr] == 0) muf = 1'b1;
                    else mcnt[v.rr]--;
                end
                if (v.iv && es == 0 && v.we && v.w != 0) mcnt[v.w]++;
            end
            #1;
            check($sformatf("rand%0d busy", n), sb_if.busy, m_busy());
            check($sformatf("rand%0d underflow", n), sb_if.underflow_error, muf);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
